// File: rtl/dcache_pkg.sv
// Shared types and helpers for the dcache bank arbiter: bank FSM states,
// address-to-bank mapping and consumer ID sizing.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RELAY = 2'b10
    } bank_state_t;

    // Index width that stays at least one bit wide for single-entry sets
    function automatic int id_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CONSUMER_ID_BITS = id_bits(8);

    function automatic int bank_index(input logic [63:0] addr,
                                      input int          block_size,
                                      input int          num_banks);
        logic [63:0] shifted;
        if (num_banks <= 1) begin
            return 0;
        end
        shifted = addr >> $clog2(block_size);
        return int'(shifted & 64'(num_banks - 1));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N.
module rr_arbiter
    import dcache_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]            req,
    input  logic [id_bits(N)-1:0]   ptr,
    output logic                    grant_valid,
    output logic [id_bits(N)-1:0]   grant_idx
);

    localparam int IW = id_bits(N);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!grant_valid && req[(int'(ptr) + k) % N]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/dcache_bank_arbiter.sv
// Shares the dcache banks between LSU consumers: per-bank round-robin grant,
// then a three-state sequencer that issues to the bank and relays completion.
module dcache_bank_arbiter
    import dcache_pkg::*;
#(
    parameter int ADDR_BITS        = 8,
    parameter int NUM_CONSUMERS    = 8,
    parameter int NUM_BANKS        = 2,
    parameter int CACHE_BLOCK_SIZE = 1
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [NUM_CONSUMERS-1:0]                            consumer_req_valid,
    input  logic [NUM_CONSUMERS-1:0]                            consumer_req_write,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]             consumer_req_address,
    output logic [NUM_CONSUMERS-1:0]                            consumer_req_ready,
    output logic [NUM_BANKS-1:0]                                bank_req_valid,
    output logic [NUM_BANKS-1:0]                                bank_req_write,
    output logic [NUM_BANKS-1:0][ADDR_BITS-1:0]                 bank_req_address,
    output logic [NUM_BANKS-1:0][id_bits(NUM_CONSUMERS)-1:0]    bank_req_consumer,
    input  logic [NUM_BANKS-1:0]                                bank_resp_valid
);

    localparam int CID_W = id_bits(NUM_CONSUMERS);

    bank_state_t [NUM_BANKS-1:0]                state_q, state_d;
    logic [NUM_BANKS-1:0][CID_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [NUM_BANKS-1:0]                       req_valid_q, req_valid_d;
    logic [NUM_BANKS-1:0]                       req_write_q, req_write_d;
    logic [NUM_BANKS-1:0][ADDR_BITS-1:0]        req_addr_q, req_addr_d;
    logic [NUM_BANKS-1:0][CID_W-1:0]            req_cons_q, req_cons_d;
    logic [NUM_CONSUMERS-1:0]                   served_q, served_d;
    logic [NUM_CONSUMERS-1:0]                   ready_q, ready_d;

    logic [NUM_BANKS-1:0][NUM_CONSUMERS-1:0]    elig;
    logic [NUM_BANKS-1:0]                       gnt_valid;
    logic [NUM_BANKS-1:0][CID_W-1:0]            gnt_idx;

    // A served consumer stays out of arbitration until it drops valid in RELAY
    always_comb begin
        elig = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int j = 0; j < NUM_CONSUMERS; j++) begin
                if (consumer_req_valid[j] && !served_q[j] &&
                    bank_index(64'(consumer_req_address[j]), CACHE_BLOCK_SIZE, NUM_BANKS) == b) begin
                    elig[b][j] = 1'b1;
                end
            end
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank_arb
        rr_arbiter #(
            .N (NUM_CONSUMERS)
        ) u_rr_arbiter (
            .req         (elig[gb]),
            .ptr         (rr_ptr_q[gb]),
            .grant_valid (gnt_valid[gb]),
            .grant_idx   (gnt_idx[gb])
        );
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        req_valid_d = req_valid_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_cons_d  = req_cons_q;
        served_d    = served_q;
        ready_d     = ready_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            case (state_q[b])
                IDLE: begin
                    if (gnt_valid[b]) begin
                        req_valid_d[b]       = 1'b1;
                        req_write_d[b]       = consumer_req_write[gnt_idx[b]];
                        req_addr_d[b]        = consumer_req_address[gnt_idx[b]];
                        req_cons_d[b]        = gnt_idx[b];
                        served_d[gnt_idx[b]] = 1'b1;
                        rr_ptr_d[b]          = (gnt_idx[b] == CID_W'(NUM_CONSUMERS - 1))
                                               ? '0 : gnt_idx[b] + CID_W'(1);
                        state_d[b]           = ISSUE;
                    end
                end
                ISSUE: begin
                    if (bank_resp_valid[b]) begin
                        req_valid_d[b]         = 1'b0;
                        ready_d[req_cons_q[b]] = 1'b1;
                        state_d[b]             = RELAY;
                    end
                end
                RELAY: begin
                    // Responses arriving here belong to no request and are dropped
                    if (!consumer_req_valid[req_cons_q[b]]) begin
                        ready_d[req_cons_q[b]]  = 1'b0;
                        served_d[req_cons_q[b]] = 1'b0;
                        state_d[b]              = IDLE;
                    end
                end
                default: begin
                    state_d[b] = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= IDLE;
            end
            rr_ptr_q    <= '0;
            req_valid_q <= '0;
            req_write_q <= '0;
            req_addr_q  <= '0;
            req_cons_q  <= '0;
            served_q    <= '0;
            ready_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_cons_q  <= req_cons_d;
            served_q    <= served_d;
            ready_q     <= ready_d;
        end
    end

    assign consumer_req_ready = ready_q;
    assign bank_req_valid     = req_valid_q;
    assign bank_req_write     = req_write_q;
    assign bank_req_address   = req_addr_q;
    assign bank_req_consumer  = req_cons_q;

endmodule
